// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared op encoding, FSM states and default sizes for the mul/div sequencer.
package muldiv_sequencer_pkg;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_ADRW = 4;
    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: CPU-side request and register-file writeback bundle of the mul/div sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = muldiv_sequencer_pkg::DEF_WIDTH,
    parameter int ADRW = muldiv_sequencer_pkg::DEF_ADRW
);
    logic start;
    logic op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [ADRW-1:0] dstAdr;
    logic busy;
    logic done;
    logic writeEn;
    logic [ADRW-1:0] writeAdr;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH-1:0] hiData;
    logic divByZero;
    modport master (
        output start, op, srcA, srcB, dstAdr,
        input busy, done, writeEn, writeAdr, writeData, hiData, divByZero
    );
    modport slave (
        input start, op, srcA, srcB, dstAdr,
        output busy, done, writeEn, writeAdr, writeData, hiData, divByZero
    );
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: one shift-add multiply or restoring divide step per cycle; lo/hi are the post-step values.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] acc, sh, m;
    logic op_r;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] sum, r;
    logic ge;
    // A zero divisor makes every trial subtract succeed, which yields all-ones and the dividend with no special case.
    always_comb begin
        sum = {1'b0, acc} + (sh[0] ? {1'b0, m} : '0);
        r = {acc, sh[WIDTH-1]};
        ge = r >= {1'b0, m};
        lo = op_r == OP_MUL ? {sum[0], sh[WIDTH-1:1]} : {sh[WIDTH-2:0], ge};
        hi = op_r == OP_MUL ? sum[WIDTH:1] : (ge ? r[WIDTH-1:0] - m : r[WIDTH-1:0]);
    end
    assign last = cnt == CW'(WIDTH - 1);
    assign dz = op_r == OP_DIV && m == '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc <= '0;
            sh <= '0;
            m <= '0;
            op_r <= OP_MUL;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            sh <= a;
            m <= b;
            op_r <= op;
            cnt <= '0;
        end else if (step) begin
            acc <= hi;
            sh <= lo;
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: IDLE/CALC/WB control around the iterative datapath, with registered writeback outputs.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADRW = DEF_ADRW
) (
    input logic clk,
    input logic rst,
    muldiv_sequencer_if.slave bus
);
    state_t state;
    logic [ADRW-1:0] dst;
    logic [WIDTH-1:0] lo, hi;
    logic last, dz;
    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (state == IDLE && bus.start),
        .step (state == CALC),
        .op   (bus.op),
        .a    (bus.srcA),
        .b    (bus.srcB),
        .lo   (lo),
        .hi   (hi),
        .last (last),
        .dz   (dz)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            dst <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.writeEn <= 1'b0;
            bus.writeAdr <= '0;
            bus.writeData <= '0;
            bus.hiData <= '0;
            bus.divByZero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.writeEn <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state <= CALC;
                    bus.busy <= 1'b1;
                    dst <= bus.dstAdr;
                end
                CALC: if (last) begin
                    state <= WB;
                    bus.done <= 1'b1;
                    bus.writeEn <= dst != '0;
                    bus.writeAdr <= dst;
                    bus.writeData <= lo;
                    bus.hiData <= hi;
                    bus.divByZero <= dz;
                end
                WB: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed mul/div vectors checked against an arithmetic model every cycle plus literal results.
module tb_muldiv_sequencer;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    muldiv_sequencer_if #(.WIDTH(W), .ADRW(4)) bus ();
    muldiv_sequencer #(.WIDTH(W), .ADRW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: cycles left until idle, and the operation's expected outputs from plain arithmetic.
    int left;
    logic m_op, m_done, m_we, m_dz;
    logic [7:0] m_a, m_b, m_wd, m_hi;
    logic [3:0] m_dst, m_adr;
    always @(posedge clk or posedge rst)
        if (rst) begin
            left <= 0;
            m_done <= 1'b0;
            m_we <= 1'b0;
            m_adr <= '0;
            m_wd <= '0;
            m_hi <= '0;
            m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_we <= 1'b0;
            if (left == 0 && bus.start) begin
                left <= W + 1;
                m_op <= bus.op;
                m_a <= bus.srcA;
                m_b <= bus.srcB;
                m_dst <= bus.dstAdr;
            end else if (left == 2) begin
                left <= 1;
                m_done <= 1'b1;
                m_we <= m_dst != 0;
                m_adr <= m_dst;
                m_dz <= m_op && m_b == 0;
                if (!m_op) {m_hi, m_wd} <= 16'(m_a) * 16'(m_b);
                else if (m_b == 0) {m_hi, m_wd} <= {m_a, 8'hFF};
                else {m_hi, m_wd} <= {m_a % m_b, m_a / m_b};
            end else if (left > 0) left <= left - 1;
        end

    always @(negedge clk) begin
        chk("busy", bus.busy, left != 0);
        chk("done", bus.done, m_done);
        chk("writeEn", bus.writeEn, m_we);
        chk("writeData", bus.writeData, m_wd);
        chk("hiData", bus.hiData, m_hi);
        chk("divByZero", bus.divByZero, m_dz);
        if (m_done) chk("writeAdr", bus.writeAdr, m_adr);
    end

    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b, input logic [3:0] adr,
                          input int pulse_at, output int wb, output int ndone, output int nwe);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = o;
        bus.srcA = a;
        bus.srcB = b;
        bus.dstAdr = adr;
        @(posedge clk);
        @(negedge clk);
        bus.op = ~o;
        bus.srcA = 8'($urandom);
        bus.srcB = 8'($urandom);
        bus.dstAdr = 4'($urandom);
        wb = -1;
        ndone = 0;
        nwe = 0;
        for (int c = 1; c <= 14; c++) begin
            bus.start = (c == pulse_at);
            if (bus.done) begin
                if (wb < 0) wb = c;
                ndone++;
            end
            if (bus.writeEn) nwe++;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int wb, nd, nw;
        bus.start = 1'b0;
        bus.op = 1'b0;
        bus.srcA = '0;
        bus.srcB = '0;
        bus.dstAdr = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_writeData", bus.writeData, 0);
        chk("rst_writeAdr", bus.writeAdr, 0);
        rst = 1'b0;

        run_op(1'b0, 8'd13, 8'd11, 4'd3, 0, wb, nd, nw);
        chk("mul13x11_wb_cycle", wb, 9);
        chk("mul13x11_lo", bus.writeData, 8'h8F);
        chk("mul13x11_hi", bus.hiData, 8'h00);
        chk("mul13x11_we", nw, 1);
        chk("mul13x11_adr", bus.writeAdr, 3);

        run_op(1'b0, 8'd200, 8'd3, 4'd7, 0, wb, nd, nw);
        chk("mul200x3_lo", bus.writeData, 8'h58);
        chk("mul200x3_hi", bus.hiData, 8'h02);
        chk("mul200x3_dz", bus.divByZero, 0);

        run_op(1'b1, 8'd200, 8'd7, 4'd9, 0, wb, nd, nw);
        chk("div200by7_q", bus.writeData, 8'h1C);
        chk("div200by7_r", bus.hiData, 8'h04);

        run_op(1'b1, 8'h2A, 8'd0, 4'd2, 0, wb, nd, nw);
        chk("div0_wb_cycle", wb, 9);
        chk("div0_q", bus.writeData, 8'hFF);
        chk("div0_r", bus.hiData, 8'h2A);
        chk("div0_dz", bus.divByZero, 1);

        run_op(1'b0, 8'd9, 8'd7, 4'd4, 3, wb, nd, nw);
        chk("restart_ndone", nd, 1);
        chk("restart_lo", bus.writeData, 8'h3F);
        chk("restart_dz", bus.divByZero, 0);

        run_op(1'b0, 8'd5, 8'd5, 4'd0, 0, wb, nd, nw);
        chk("r0_wb_cycle", wb, 9);
        chk("r0_ndone", nd, 1);
        chk("r0_we", nw, 0);
        chk("r0_lo", bus.writeData, 8'h19);

        run_op(1'b0, 8'd3, 8'd4, 4'd1, 9, wb, nd, nw);
        chk("wbstart_ndone", nd, 1);
        chk("wbstart_lo", bus.writeData, 8'h0C);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 1'b1;
        bus.srcA = 8'd200;
        bus.srcB = 8'd7;
        bus.dstAdr = 4'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_we", bus.writeEn, 0);
        chk("abort_adr", bus.writeAdr, 0);
        chk("abort_lo", bus.writeData, 0);
        chk("abort_hi", bus.hiData, 0);
        chk("abort_dz", bus.divByZero, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        nw = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.writeEn) nw++;
        end
        chk("abort_ndone", nd, 0);
        chk("abort_nwe", nw, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
